y86_data_mem: RTL

Data-memory responder for the Y86 processor: accepts one 64-bit read or write request at a time from the memory stage over a valid/ready handshake, holds it for a fixed access latency, then returns read data and an error flag over a valid/ready response channel. It replaces direct array access from the memory stage. Out-of-range or misaligned accesses produce an error response and latch a sticky halt that blocks further requests until reset.

---
 rtl/y86_mem_pkg.sv | 30 +++
 rtl/y86_data_mem_if.sv | 25 ++
 rtl/y86_mem_array.sv | 24 ++
 rtl/y86_data_mem.sv | 138 +++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// rtl/y86_mem_pkg.sv - shared types and constants for the Y86 data memory
package y86_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HALT
  } mem_state_t;

  // Y86 instruction codes that reach the data memory
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam int WORD_BYTES = 8;

  // Full-width range check: the word index is never truncated before comparing.
  function automatic logic addr_fault(input logic [63:0] addr, input int depth_words);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr & 64'(WORD_BYTES - 1)) != 64'd0;
    out_of_range = {3'b000, addr[63:3]} >= 64'(depth_words);
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/y86_data_mem_if.sv
// rtl/y86_data_mem_if.sv - request/response bus between memory stage and data memory
interface y86_data_mem_if;

  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        halted;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, halted
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, halted
  );

endinterface

// File: rtl/y86_mem_array.sv
// rtl/y86_mem_array.sv - single-port word storage, synchronous write, combinational read
module y86_mem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  // write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/y86_data_mem.sv
// rtl/y86_data_mem.sv - latency-controlled data memory responder with sticky fault halt
module y86_data_mem
  import y86_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input logic           clk,
  input logic           rst,
  y86_data_mem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_state_t  state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [63:0] cap_addr;
  logic [63:0] cap_wdata;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;
  logic        halted_q;

  logic             acc_write;
  logic [63:0]      acc_addr;
  logic [63:0]      acc_wdata;
  logic             do_access;
  logic             fault;
  logic             we;
  logic [IDX_W-1:0] idx;
  logic [63:0]      arr_rdata;

  // With LATENCY=1 the access happens on the accept edge, straight from the bus
  always_comb begin
    acc_write = cap_write;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    do_access = 1'b0;
    if (state == ST_IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      do_access = bus.req_valid && (LATENCY == 1);
    end else if (state == ST_WAIT) begin
      do_access = (cnt == 4'd0);
    end
  end

  assign fault = addr_fault(acc_addr, DEPTH_WORDS);
  assign idx   = acc_addr[IDX_W+2:3];
  // reset on the access edge discards the pending write
  assign we    = do_access && acc_write && !fault && !rst;

  y86_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .idx  (idx),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  // request/latency/response FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      cap_write    <= 1'b0;
      cap_addr     <= 64'd0;
      cap_wdata    <= 64'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cap_write   <= bus.req_write;
            cap_addr    <= bus.req_addr;
            cap_wdata   <= bus.req_wdata;
            cnt         <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= (fault || acc_write) ? 64'd0 : arr_rdata;
              resp_err_q   <= fault;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state        <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= (fault || acc_write) ? 64'd0 : arr_rdata;
            resp_err_q   <= fault;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            if (resp_err_q) begin
              state    <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              state       <= ST_IDLE;
              req_ready_q <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          req_ready_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.halted     = halted_q;

endmodule
